roba_seq_ctrl: RTL

ROBA_SEQ_CTRL -- requirements
Module: roba_seq_ctrl

---
 rtl/roba_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/roba_seq_ctrl.sv
// Sequential signed multiplier built around one shared ROBA approximate core.
// An optional second pass refines the product using the residual operands.
module roba_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        two_pass,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        PASS1,
        PASS2,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic [31:0] x_q, y_q;
    logic        tp_q;
    logic [31:0] a, b;
    logic [31:0] da, db;
    logic        s;
    logic [63:0] acc;

    // Index of the highest set bit; 0 when the value is zero.
    function automatic logic [4:0] msb_idx(input logic [31:0] v);
        logic [4:0] k;
        k = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) k = 5'(i);
        end
        return k;
    endfunction

    // Shared ROBA core: operands switch to the residuals during PASS2.
    logic [31:0] core_a, core_b;
    logic [4:0]  ka, kb;
    logic [31:0] ar, br;
    logic [63:0] pp, zz, roba;
    logic [63:0] mag, p_nxt;

    always_comb begin
        core_a = (state == PASS2) ? da : a;
        core_b = (state == PASS2) ? db : b;
        ka     = msb_idx(core_a);
        kb     = msb_idx(core_b);
        ar     = 32'd1 << ka;
        br     = 32'd1 << kb;
        pp     = ({32'd0, core_a} << kb) + ({32'd0, core_b} << ka);
        zz     = {32'd0, ar} << kb;
        roba   = (pp ^ zz) & ~(((~pp) & zz) << 1);
        mag    = (state == PASS2) ? (acc + roba) : roba;
        p_nxt  = s ? (64'd0 - mag) : mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ABS;
            end
            ABS:   state_nxt = PASS1;
            PASS1: state_nxt = tp_q ? PASS2 : OUT;
            PASS2: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            tp_q <= 1'b0;
            a    <= '0;
            b    <= '0;
            s    <= 1'b0;
            da   <= '0;
            db   <= '0;
            acc  <= '0;
            p    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q  <= x;
                        y_q  <= y;
                        tp_q <= two_pass;
                    end
                end
                ABS: begin
                    a <= x_q[31] ? (32'd0 - x_q) : x_q;
                    b <= y_q[31] ? (32'd0 - y_q) : y_q;
                    s <= x_q[31] ^ y_q[31];
                end
                PASS1: begin
                    acc <= roba;
                    da  <= a ^ ar;
                    db  <= b ^ br;
                    if (!tp_q) p <= p_nxt;
                end
                PASS2: p <= p_nxt;
                default: ;
            endcase
        end
    end

endmodule
